// File: rtl/deinterleaver_rx.sv
// deinterleaver_rx
//   Receive-side block deinterleaver. Collects SYM_W-bit interleaved symbols
//   into a ROWS x COLS bit matrix (column-wise write) and replays the bits in
//   original row-wise order, one bit per clock.
//
//   Optional feature: define DEINTERLEAVER_PINGPONG_EN for a two-bank build
//   (fill one bank while the other drains). Without it a single bank is used
//   and input is stalled while the block drains.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_bits     interleaved symbol, in_bits[SYM_W-1] is the earliest bit
//   data_valid  in_bits valid this cycle
//   in_ready    symbol accepted when data_valid && in_ready
//   out_bit     restored serial bit (0 when out_valid=0)
//   out_valid   out_bit valid this cycle
//   block_done  pulse with the last bit of a block
//   overrun     sticky: a symbol was offered while in_ready=0
module deinterleaver_rx #(
    parameter int ROWS  = 16,
    parameter int COLS  = 8,
    parameter int SYM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] in_bits,
    input  logic             data_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             block_done,
    output logic             overrun
);

    localparam int N    = ROWS * COLS;
    localparam int NSYM = N / SYM_W;
    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int JW   = (NSYM > 1) ? $clog2(NSYM) : 1;

`ifdef DEINTERLEAVER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam bit PP = (NB == 2);

    localparam logic [JW-1:0] J_LAST = JW'(NSYM - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          wr_bank;
    logic          rd_bank;
    logic [NB-1:0] full;     // bank holds a complete block not yet drained
    logic [N-1:0]  mem [NB];

    logic accept, fill_done, last_bit, other_bank, start_rd, chain_next;

    // Stream position of symbol j lane b, mapped to its original bit index.
    function automatic int map_idx(input int sj, input int b);
        int p;
        p = SYM_W * sj + (SYM_W - 1 - b);
        return (p % ROWS) * COLS + p / ROWS;
    endfunction

    always_comb begin
        in_ready   = ~full[wr_bank];
        accept     = data_valid & in_ready;
        fill_done  = accept && (j == J_LAST);
        last_bit   = (state == DRAIN) && (k == K_LAST);
        other_bank = PP ? ~rd_bank : rd_bank;
        // Drain may begin on the very edge that completes the bank, which
        // gives the one-cycle latency from final symbol to first bit.
        start_rd   = full[rd_bank] || (fill_done && (wr_bank == rd_bank));
        // With two banks, roll straight into the next block when it is ready.
        chain_next = PP && (full[other_bank] || (fill_done && (wr_bank == other_bank)));
    end

    assign out_valid  = (state == DRAIN);
    assign out_bit    = out_valid & mem[rd_bank][k];
    assign block_done = last_bit;

    // Buffer is not reset; its content is don't-care until rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < SYM_W; b++)
                mem[wr_bank][KW'(map_idx(32'(j), b))] <= in_bits[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            j       <= '0;
            k       <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            overrun <= 1'b0;
        end else begin
            if (data_valid && !in_ready)
                overrun <= 1'b1;

            if (accept)
                j <= fill_done ? '0 : j + JW'(1);

            // Set and clear never hit the same bank: a draining bank is full,
            // so it cannot be the one being filled.
            if (last_bit)
                full[rd_bank] <= 1'b0;
            if (fill_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= PP ? ~wr_bank : 1'b0;
            end

            case (state)
                FILL: begin
                    if (start_rd) begin
                        state <= DRAIN;
                        k     <= '0;
                    end
                end
                DRAIN: begin
                    if (k == K_LAST) begin
                        k       <= '0;
                        rd_bank <= other_bank;
                        state   <= chain_next ? DRAIN : FILL;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_deinterleaver_rx.sv
// Self-checking bench for deinterleaver_rx: a 16x8x4 instance (a_*) and a
// 4x4x2 instance (b_*). Expected output bits are queued when a block is sent
// and popped by per-instance monitors as the DUT produces them.
module tb_deinterleaver_rx;

    localparam logic [127:0] PAT = 128'hA5A5_5A5A_F0F0_0F0F_1234_ABCD_5678_EEEE;
    // 4x4x2 ramp (symbols 0,1,2,3,0,1,2,3) restored order, k=0 at MSB.
    localparam logic [15:0]  B_EXP = 16'h505F;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [3:0] a_in = '0;
    logic       a_dv = 1'b0;
    logic       a_rdy, a_bit, a_valid, a_done, a_ovr;
    logic [1:0] b_in = '0;
    logic       b_dv = 1'b0;
    logic       b_rdy, b_bit, b_valid, b_done, b_ovr;

    deinterleaver_rx #(.ROWS(16), .COLS(8), .SYM_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bits(a_in), .data_valid(a_dv),
        .in_ready(a_rdy), .out_bit(a_bit), .out_valid(a_valid),
        .block_done(a_done), .overrun(a_ovr));

    deinterleaver_rx #(.ROWS(4), .COLS(4), .SYM_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bits(b_in), .data_valid(b_dv),
        .in_ready(b_rdy), .out_bit(b_bit), .out_valid(b_valid),
        .block_done(b_done), .overrun(b_ovr));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct { logic b; logic last; } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    int a_run = 0, a_last_run = 0, a_runs = 0, a_nout = 0;
    int b_run = 0, b_last_run = 0, b_runs = 0;

    always @(negedge clk) begin
        if (a_valid) begin
            exp_t e;
            a_run++;
            a_nout++;
            if (qa.size() == 0) check("a_extra_bit", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_out_bit", a_bit, e.b);
                check("a_block_done", a_done, e.last);
            end
        end else begin
            check("a_idle_out", {a_bit, a_done}, 2'b00);
            if (a_run != 0) begin a_last_run = a_run; a_run = 0; a_runs++; end
        end
    end

    always @(negedge clk) begin
        if (b_valid) begin
            exp_t e;
            b_run++;
            if (qb.size() == 0) check("b_extra_bit", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_out_bit", b_bit, e.b);
                check("b_block_done", b_done, e.last);
            end
        end else begin
            check("b_idle_out", {b_bit, b_done}, 2'b00);
            if (b_run != 0) begin b_last_run = b_run; b_run = 0; b_runs++; end
        end
    end

    // Interleave: stream position p of symbol j lane b carries original bit k.
    function automatic logic [3:0] a_sym(input logic [127:0] pat, input int j);
        logic [3:0] s;
        for (int b = 0; b < 4; b++) begin
            int p, k;
            p = 4 * j + 3 - b;
            k = (p % 16) * 8 + p / 16;
            s[b] = pat[127 - k];
        end
        return s;
    endfunction

    // Called and returns at posedge+1.
    task automatic a_send(input logic [127:0] pat, input bit gaps, input bit hold, input bit chk_lat);
        for (int i = 0; i < 128; i++) qa.push_back('{pat[127 - i], i == 127});
        for (int j = 0; j < 32; j++) begin
            bit ok;
            a_in = a_sym(pat, j);
            a_dv = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (a_rdy) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            if (!ok) check("a_ready_timeout", 0, 1);
            if (j == 31 && chk_lat) check("a_valid_before_last", a_valid, 0);
            @(posedge clk); #1;
            if (gaps && (j % 5 == 4) && j != 31) begin
                a_dv = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
        end
        if (!hold) a_dv = 1'b0;
        if (chk_lat) check("a_first_bit_latency", a_valid, 1);
    endtask

    task automatic a_wait_run(input string tag, input int exp_len);
        int base;
        bit ok;
        base = a_runs;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            if (a_runs != base) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
        else check(tag, a_last_run, exp_len);
    endtask

    task automatic b_send();
        for (int i = 0; i < 16; i++) qb.push_back('{B_EXP[15 - i], i == 15});
        for (int j = 0; j < 8; j++) begin
            bit ok;
            b_in = j[1:0];
            b_dv = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                if (b_rdy) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            if (!ok) check("b_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        b_dv = 1'b0;
        check("b_first_bit_latency", b_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", a_rdy, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_overrun", a_ovr, 0);
        check("rst_a_out", {a_bit, a_done}, 2'b00);
        check("rst_b_ready", b_rdy, 1);
        check("tb_symbol0", a_sym(PAT, 0), 4'hC);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single block.
        a_send(PAT, 1'b0, 1'b0, 1'b1);
        a_wait_run("a_run_plain", 128);
        check("a_ready_after_drain", a_rdy, 1);

`ifdef DEINTERLEAVER_PINGPONG_EN
        // Two blocks with data_valid held high drain as one continuous run.
        a_send(PAT, 1'b0, 1'b1, 1'b1);
        a_send(~PAT, 1'b0, 1'b0, 1'b0);
        a_wait_run("a_run_pingpong", 256);
        check("a_pp_no_overrun", a_ovr, 0);
`else
        // Symbol offered during drain is dropped and flags overrun.
        a_send(PAT, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        a_in = 4'hF;
        a_dv = 1'b1;
        check("a_ready_in_drain", a_rdy, 0);
        @(posedge clk); #1;
        a_dv = 1'b0;
        check("a_overrun_set", a_ovr, 1);
        a_wait_run("a_run_overrun", 128);
        check("a_overrun_held", a_ovr, 1);
`endif

        // Gapped input: same output; also proves a dropped symbol left j alone.
        a_send(PAT, 1'b1, 1'b0, 1'b1);
        a_wait_run("a_run_gaps", 128);

        // Asynchronous reset mid-drain after 100 bits.
        a_send(PAT, 1'b0, 1'b0, 1'b0);
        begin
            int base;
            bit ok;
            base = a_nout;
            ok = 1'b0;
            for (int t = 0; t < 500; t++) begin
                @(posedge clk); #1;
                if (a_nout >= base + 100) begin ok = 1'b1; break; end
            end
            if (!ok) check("a_100_bits_timeout", 0, 1);
        end
        rst_n = 1'b0;
        #1;
        check("a_async_rst_valid", a_valid, 0);
        check("a_async_rst_overrun", a_ovr, 0);
        check("a_async_rst_ready", a_rdy, 1);
        qa.delete();
        a_wait_run("a_run_truncated", 100);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_send('1, 1'b0, 1'b0, 1'b1);
        a_wait_run("a_run_ones", 128);

        // Small geometry instance.
        b_send();
        begin
            int base;
            bit ok;
            base = b_runs;
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(posedge clk); #1;
                if (b_runs != base) begin ok = 1'b1; break; end
            end
            if (!ok) check("b_run_timeout", 0, 1);
            else check("b_run_len", b_last_run, 16);
        end
        check("b_no_overrun", b_ovr, 0);
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
